// File: rtl/mig7_arbiter.sv
// Two-client arbiter for the MIG7 app interface: serializes single-beat commands and
// routes read returns back to their issuer. Define MIG7_ARB_RR_EN for round-robin arbitration.
module mig7_arbiter #(
    parameter int AWIDTH    = 28,
    parameter int DWIDTH    = 128,
    parameter int MWIDTH    = 16,
    parameter int RDQ_DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c0_valid,
    input  logic                         c0_wr,
    input  logic [AWIDTH-1:0]            c0_addr,
    input  logic [DWIDTH-1:0]            c0_wdata,
    input  logic [MWIDTH-1:0]            c0_wmask,
    output logic                         c0_ready,
    output logic [DWIDTH-1:0]            c0_rdata,
    output logic                         c0_rvalid,
    input  logic                         c1_valid,
    input  logic                         c1_wr,
    input  logic [AWIDTH-1:0]            c1_addr,
    input  logic [DWIDTH-1:0]            c1_wdata,
    input  logic [MWIDTH-1:0]            c1_wmask,
    output logic                         c1_ready,
    output logic [DWIDTH-1:0]            c1_rdata,
    output logic                         c1_rvalid,
    output logic [AWIDTH-1:0]            app_addr,
    output logic [2:0]                   app_cmd,
    output logic                         app_en,
    output logic [DWIDTH-1:0]            app_wdf_data,
    output logic                         app_wdf_end,
    output logic [MWIDTH-1:0]            app_wdf_mask,
    output logic                         app_wdf_wren,
    input  logic                         app_rdy,
    input  logic                         app_wdf_rdy,
    input  logic [DWIDTH-1:0]            app_rd_data,
    input  logic                         app_rd_data_valid,
    input  logic                         app_rd_data_end,
    output logic                         app_sr_req,
    output logic                         app_ref_req,
    output logic                         app_zq_req,
    input  logic                         init_calib_complete,
    output logic [$clog2(RDQ_DEPTH):0]   rd_pending,
    output logic                         rd_err,
    output logic                         state_dbg
);
    localparam int PW = $clog2(RDQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state;
    logic            issue_id;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            tag_mem [RDQ_DEPTH];

    logic            fifo_full;
    logic            fifo_empty;
    logic            elig0;
    logic            elig1;
    logic            can_grant;
    logic            sel;
    logic            push;
    logic            pop;
    logic            pop_tag;
    logic            w_wr;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_wdata;
    logic [MWIDTH-1:0] w_wmask;
    logic            unused_inputs;

    assign unused_inputs = app_rd_data_end;
    assign app_sr_req    = 1'b0;
    assign app_ref_req   = 1'b0;
    assign app_zq_req    = 1'b0;
    assign state_dbg     = (state == ISSUE);

    assign fifo_full  = (rd_pending == CW'(RDQ_DEPTH));
    assign fifo_empty = (rd_pending == '0);

    // Client handshake: a command transfers in the cycle where cK_valid and cK_ready are
    // both high; cK_ready never rises outside IDLE, during reset, or before calibration.
    assign elig0     = c0_valid & (c0_wr | ~fifo_full);
    assign elig1     = c1_valid & (c1_wr | ~fifo_full);
    assign can_grant = rst_n & (state == IDLE) & init_calib_complete & (elig0 | elig1);

`ifdef MIG7_ARB_RR_EN
    logic last_grant;

    assign sel = (elig0 & elig1) ? ~last_grant : elig1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (can_grant) begin
            last_grant <= sel;
        end
    end
`else
    assign sel = ~elig0;
`endif

    assign c0_ready = can_grant & ~sel;
    assign c1_ready = can_grant & sel;

    assign w_wr    = sel ? c1_wr    : c0_wr;
    assign w_addr  = sel ? c1_addr  : c0_addr;
    assign w_wdata = sel ? c1_wdata : c0_wdata;
    assign w_wmask = sel ? c1_wmask : c0_wmask;

    // A read is owed data only once the controller has taken the command.
    assign push    = app_en & app_rdy & (app_cmd == CMD_READ);
    assign pop     = app_rd_data_valid & ~fifo_empty;
    assign pop_tag = tag_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            tag_mem[wr_ptr] <= issue_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            issue_id     <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_pending   <= '0;
            rd_err       <= 1'b0;
            c0_rvalid    <= 1'b0;
            c1_rvalid    <= 1'b0;
            c0_rdata     <= '0;
            c1_rdata     <= '0;
        end else begin
            c0_rvalid <= pop & ~pop_tag;
            c1_rvalid <= pop & pop_tag;
            if (pop && !pop_tag) begin
                c0_rdata <= app_rd_data;
            end
            if (pop && pop_tag) begin
                c1_rdata <= app_rd_data;
            end
            if (app_rd_data_valid && fifo_empty) begin
                rd_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            rd_pending <= rd_pending + CW'(push) - CW'(pop);

            case (state)
                IDLE: begin
                    if (can_grant) begin
                        app_addr <= w_addr;
                        app_cmd  <= w_wr ? CMD_WRITE : CMD_READ;
                        app_en   <= 1'b1;
                        issue_id <= sel;
                        if (w_wr) begin
                            app_wdf_data <= w_wdata;
                            app_wdf_mask <= w_wmask;
                            app_wdf_wren <= 1'b1;
                            app_wdf_end  <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Command and write-data acceptances are tracked independently.
                    if (app_rdy) begin
                        app_en <= 1'b0;
                    end
                    if (app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                    end
                    if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mig7_arbiter.sv
// Self-checking bench for mig7_arbiter: directed scenarios with a read-return scoreboard.
// Works with or without MIG7_ARB_RR_EN defined.
module tb_mig7_arbiter;
    localparam int AW    = 28;
    localparam int DW    = 128;
    localparam int MW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic          c0_valid, c0_wr, c0_ready, c0_rvalid;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_wdata, c0_rdata;
    logic [MW-1:0] c0_wmask;
    logic          c1_valid, c1_wr, c1_ready, c1_rvalid;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_wdata, c1_rdata;
    logic [MW-1:0] c1_wmask;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_wdf_end, app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_rdy, app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid, app_rd_data_end;
    logic          app_sr_req, app_ref_req, app_zq_req;
    logic          init_calib_complete;
    logic [CW-1:0] rd_pending;
    logic          rd_err;
    logic          state_dbg;

    mig7_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MWIDTH(MW), .RDQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_valid(c0_valid), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_wmask(c0_wmask), .c0_ready(c0_ready), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
        .c1_valid(c1_valid), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_wmask(c1_wmask), .c1_ready(c1_ready), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
        .init_calib_complete(init_calib_complete), .rd_pending(rd_pending),
        .rd_err(rd_err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_err    = 0;
    logic [DW:0]   exp_q[$];
    bit            tag_q[$];
    bit            last_g = 1'b1;
    logic [DW:0]   mon_e;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c0_rvalid || c1_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", {c1_rvalid, c0_rvalid}, '0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_client", {c1_rvalid, c0_rvalid}, mon_e[DW] ? 2'b10 : 2'b01);
                check("rd_data", c1_rvalid ? c1_rdata : c0_rdata, mon_e[DW-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int k, input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        if (k == 0) begin
            c0_valid = v; c0_wr = wr; c0_addr = a; c0_wdata = d; c0_wmask = m;
        end else begin
            c1_valid = v; c1_wr = wr; c1_addr = a; c1_wdata = d; c1_wmask = m;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while ((app_en || app_wdf_wren) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("issue_done", {app_en, app_wdf_wren}, '0);
    endtask

    task automatic send(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bit rdy;
        @(negedge clk);
        drive(k, 1'b1, wr, a, d, '0);
        #1;
        rdy = (k == 0) ? c0_ready : c1_ready;
        while (!rdy && n < 50) begin
            @(negedge clk); #1; n++;
            rdy = (k == 0) ? c0_ready : c1_ready;
        end
        check("send_grant", rdy, 1'b1);
        if (rdy) begin
            last_g = k[0];
            if (!wr) tag_q.push_back(k[0]);
        end
        @(negedge clk);
        drive(k, 1'b0, 1'b0, '0, '0, '0);
        wait_idle();
    endtask

    task automatic ret(input logic [DW-1:0] d);
        @(negedge clk);
        app_rd_data_valid = 1'b1;
        app_rd_data_end   = 1'b1;
        app_rd_data       = d;
        if (tag_q.size() > 0) exp_q.push_back({tag_q.pop_front(), d});
        @(negedge clk);
        app_rd_data_valid = 1'b0;
        app_rd_data_end   = 1'b0;
        #1;
        check("rd_latency", exp_q.size(), '0);
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] a5;
    bit            seen;
    int            en_acc, wdf_acc, bad, grants, n;
    bit            g;

    initial begin
        a5 = {16{8'hA5}};
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        init_calib_complete = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_app_en", app_en, 1'b0);
        check("rst_wren", app_wdf_wren, 1'b0);
        check("rst_pending", rd_pending, '0);
        check("rst_err", rd_err, 1'b0);
        check("rst_rvalid", {c1_rvalid, c0_rvalid}, '0);
        check("rst_state", state_dbg, 1'b0);
        check("maint_req", {app_sr_req, app_ref_req, app_zq_req}, '0);

        // Calibration gate
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 28'h10, '0, '0);
        seen = 1'b0;
        repeat (20) begin
            #1; seen = seen | c0_ready | app_en;
            @(negedge clk);
        end
        check("calib_gate", seen, 1'b0);
        init_calib_complete = 1'b1;
        #1;
        check("calib_ready", c0_ready, 1'b1);
        tag_q.push_back(1'b0); last_g = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("calib_app_en", app_en, 1'b1);
        check("calib_cmd", app_cmd, 3'b001);
        check("calib_addr", app_addr, 28'h10);
        @(negedge clk); #1;
        check("calib_pending", rd_pending, 3'd1);
        ret(128'hC0DE);

        // Write with split ready
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 28'h100, a5, 16'h000F);
        #1;
        check("wr_grant", c1_ready, 1'b1);
        last_g = 1'b1;
        en_acc = 0; wdf_acc = 0; bad = 0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 1) drive(1, 1'b0, 1'b0, '0, '0, '0);
            app_rdy = (j == 3);
            app_wdf_rdy = (j == 5);
            #1;
            if (app_en && app_rdy) en_acc++;
            if (app_wdf_wren && app_wdf_rdy) wdf_acc++;
            if (state_dbg && (app_addr != 28'h100 || app_cmd != 3'b000 ||
                              app_wdf_data != a5 || app_wdf_mask != 16'h000F)) bad++;
            if (j == 1) check("wr_start", {app_en, app_wdf_wren, app_wdf_end}, 3'b111);
            if (j == 4) check("wr_en_dropped", {app_en, app_wdf_wren}, 2'b01);
            if (j == 5) check("wr_issue_held", state_dbg, 1'b1);
            if (j == 6) check("wr_idle", {state_dbg, app_wdf_wren, app_wdf_end}, '0);
        end
        check("wr_en_acc", en_acc, 1);
        check("wr_wdf_acc", wdf_acc, 1);
        check("wr_payload", bad, 0);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;

        // Read routing
        send(0, 1'b0, 28'h10, '0);
        send(1, 1'b0, 28'h20, '0);
        check("route_pending2", rd_pending, 3'd2);
        ret(128'h1111);
        ret(128'h2222);
        check("route_pending0", rd_pending, 3'd0);

        // Arbitration with both clients continuously valid
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 28'h30, 128'h30, '0);
        drive(1, 1'b1, 1'b1, 28'h31, 128'h31, '0);
        grants = 0; n = 0;
        while (grants < 8 && n < 60) begin
            #1;
            if (c0_ready || c1_ready) begin
                check("arb_single", {c1_ready, c0_ready} == 2'b11, 1'b0);
                g = c1_ready;
`ifdef MIG7_ARB_RR_EN
                check("arb_grant", g, ~last_g);
`else
                check("arb_grant", g, 1'b0);
`endif
                last_g = g;
                grants++;
            end
            @(negedge clk); n++;
        end
        check("arb_count", grants, 8);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        wait_idle();

        // Tag FIFO full
        for (int i = 0; i < 4; i++) send(i % 2, 1'b0, AW'(28'h200 + i), '0);
        check("full_pending", rd_pending, 3'd4);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 28'h300, '0, '0);
        seen = 1'b0;
        repeat (5) begin
            #1; seen = seen | c0_ready;
            @(negedge clk);
        end
        check("full_hold", seen, 1'b0);
        send(1, 1'b1, 28'h310, 128'hBEEF);
        check("full_hold2", c0_ready, 1'b0);
        check("full_pending2", rd_pending, 3'd4);
        ret(128'hA0);
        check("freed_grant", c0_ready, 1'b1);
        if (c0_ready) begin
            tag_q.push_back(1'b0); last_g = 1'b0;
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        wait_idle();
        check("freed_pending", rd_pending, 3'd4);
        for (int i = 1; i <= 4; i++) ret(DW'(128'hA0 + i));
        check("drain_pending", rd_pending, 3'd0);
        check("no_err_yet", rd_err, 1'b0);

        // Reset with reads outstanding and a write stalled in ISSUE
        send(0, 1'b0, 28'h400, '0);
        send(1, 1'b0, 28'h404, '0);
        check("rst_pending2", rd_pending, 3'd2);
        app_rdy = 1'b0;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 28'h408, 128'h77, '0);
        #1;
        check("stall_grant", c1_ready, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("stall_en", app_en, 1'b1);
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 28'h500, '0, '0);
        @(negedge clk); #1;
        check("rst_ready_gate", {c1_ready, c0_ready}, '0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b1;
        app_rdy = 1'b1;
        tag_q.delete();
        #1;
        check("mid_rst_out", {app_en, app_wdf_wren, state_dbg, rd_err}, '0);
        check("mid_rst_pending", rd_pending, '0);
        ret(128'hDEAD);
        check("err_set", rd_err, 1'b1);
        check("err_pending", rd_pending, '0);
        @(negedge clk); #1;
        check("err_sticky", rd_err, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("err_clear", rd_err, 1'b0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), '0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mig7_arbiter.md
# mig7_arbiter

Two-client arbiter for the MIG7 DDR3 user (app) interface, sitting between request sources and the `mig7series` controller in `intnode` and replacing the single-driver stub. It accepts single-beat read/write commands from two clients and serializes them onto `app_*`. It tracks outstanding reads in a tag FIFO and routes each returned read beat to the client that issued it. All logic runs in the `ui_clk` domain.

## Interface
- `AWIDTH`, default 28: app address width.
- `DWIDTH`, default 128: data width.
- `MWIDTH`, default 16: write mask width (`DWIDTH/8`).
- `RDQ_DEPTH`, default 32: maximum outstanding reads; must be a power of 2.
- `clk  in  1`: single clock, driven by MIG `ui_clk`.
- `rst_n  in  1`: synchronous, active-low reset.
- `cK_valid  in  1`: client K (K = 0, 1) has a command pending.
- `cK_wr  in  1`: 1 = write, 0 = read.
- `cK_addr  in  AWIDTH`: command address.
- `cK_wdata  in  DWIDTH`: write data, valid together with the command.
- `cK_wmask  in  MWIDTH`: write mask; 1 = byte not written.
- `cK_ready  out  1`: command accepted this cycle.
- `cK_rdata  out  DWIDTH`: read data returned to client K.
- `cK_rvalid  out  1`: `cK_rdata` is valid this cycle.
- `app_addr  out  AWIDTH`, `app_cmd  out  3`, `app_en  out  1`, `app_wdf_data  out  DWIDTH`, `app_wdf_end  out  1`, `app_wdf_mask  out  MWIDTH`, `app_wdf_wren  out  1`: MIG command and write-data channel.
- `app_rdy  in  1`, `app_wdf_rdy  in  1`, `app_rd_data  in  DWIDTH`, `app_rd_data_valid  in  1`, `app_rd_data_end  in  1`: MIG status and read channel.
- `app_sr_req  out  1`, `app_ref_req  out  1`, `app_zq_req  out  1`: maintenance requests; driven constant 0.
- `init_calib_complete  in  1`: no grant is made while this is low.
- `rd_pending  out  $clog2(RDQ_DEPTH)+1`: number of outstanding reads.
- `rd_err  out  1`: sticky flag, set when read data arrives with the tag FIFO empty.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE, grant condition: `init_calib_complete`=1, and at least one client is eligible.
  - Client K is eligible when `cK_valid`=1 and (`cK_wr`=1 or the tag FIFO is not full).
  - The arbiter asserts `cK_ready` for the winner combinationally in the same cycle.
  - The winner's command is registered into the `app_*` output registers.
  - Next state: ISSUE.
- Command encoding: read → `app_cmd`=3'b001; write → `app_cmd`=3'b000.
  - A write also sets `app_wdf_data`/`app_wdf_mask` and raises `app_wdf_wren` and `app_wdf_end`.
- ISSUE:
  - `app_en` is held until the first cycle with `app_rdy`=1, then cleared.
  - `app_wdf_wren`/`app_wdf_end` are held until the first cycle with `app_wdf_rdy`=1, then cleared.
  - The two acceptances are independent and may occur in either order or in the same cycle.
  - Once every required acceptance has occurred, the FSM returns to IDLE.
  - The `app_*` payload stays stable throughout ISSUE.
- Read tag tracking:
  - When a read is accepted (`app_en & app_rdy`), the client ID is pushed into the tag FIFO.
  - On `app_rd_data_valid`=1, a tag is popped and `app_rd_data` is registered to that client; only that client's `rvalid` pulses.
  - A push and a pop in the same cycle leave `rd_pending` unchanged.
- `app_rd_data_valid` with the FIFO empty: data is dropped, no `rvalid` is asserted, and `rd_err` is set. `rd_err` clears only on reset.
- Tag FIFO full: reads are ineligible; writes from either client are still granted.
- Reset (mid-operation included):
  - FSM → IDLE; FIFO emptied; round-robin pointer → "last=1".
  - All outputs 0, including `app_en`, `app_wdf_wren`, `rvalid`, `ready`, `rd_err`, `rd_pending`.
  - Outstanding reads are forgotten; data returning afterwards sets `rd_err`.

## Timing
- Client `valid`/`ready` handshake at cycle N → `app_en` (and `app_wdf_wren` for writes) at N+1.
- Peak throughput: 1 command per 2 cycles (IDLE bubble), assuming `app_rdy`=`app_wdf_rdy`=1.
- Read return: `app_rd_data_valid` at cycle M → `cK_rvalid` at M+1 (registered).
- `cK_ready` is never asserted while in ISSUE or while `rst_n`=0.
- `rd_pending` is registered and updates one cycle after a push or pop.

## Configuration
- Macro `MIG7_ARB_RR_EN`.
- Defined: round-robin arbitration. When both clients are eligible, grant the client not granted last; the pointer updates on every grant.
- Undefined: fixed priority, client 0 always wins. The pointer logic is removed.

## Test plan
- Calibration gate: `init_calib_complete`=0, `c0_valid`=1 for 20 cycles → no `c0_ready`, `app_en`=0. Raise it → `c0_ready` next cycle, then `app_en` 1 cycle later.
- Write with split ready: `c1` write, addr 0x100, data 0xA5…A5; `app_rdy` at +3, `app_wdf_rdy` at +5.
  - `app_cmd`=0, payload stable until both acceptances.
  - IDLE after +5.
  - Exactly one `app_en` acceptance and one `app_wdf_wren` acceptance.
- Read routing: `c0` reads 0x10, then `c1` reads 0x20; return 0x1111 then 0x2222.
  - `c0_rvalid` with 0x1111, then `c1_rvalid` with 0x2222, each 1 cycle after `app_rd_data_valid`.
  - `rd_pending` 2→0.
- Arbitration, both valid continuously for 8 grants:
  - with `MIG7_ARB_RR_EN`: grants alternate 0,1,0,1…;
  - without it: all 8 grants go to client 0.
- FIFO full: `RDQ_DEPTH`=4, 4 reads issued with no data returned.
  - 5th read is held off; a write from `c1` is still granted.
  - One return frees a slot, and the read is granted.
- Reset/error: reset with 2 reads outstanding, then drive `app_rd_data_valid`.
  - No `rvalid`, `rd_err`=1, `rd_pending`=0.
